write_addr_dec_pipelined: RTL and testbench

Parametrised write-address decoder for the AXI4 interconnect. It sits between one master AW port and `SLAVES_NUM` slave AW ports. Each accepted AW beat is decoded from the top address bits, registered, and presented to exactly one slave. A matching slave-select entry is queued in a routing FIFO, so the write-data mux can steer W beats in AW order. Unmapped addresses are consumed and flagged instead of stalling the master.

---
 rtl/write_addr_dec_pipelined.sv | 169 ++++++++++++++++
 tb/tb_write_addr_dec_pipelined.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_addr_dec_pipelined.sv
// AXI4 write-address decoder: routes each AW beat to one slave through a registered
// holding stage and queues a slave-select entry so the W mux can follow AW order.
module write_addr_dec_pipelined #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ID_WIDTH    = 1,
  parameter int SLAVES_NUM  = 4,
  parameter int SEL_BITS    = 2,
  parameter int ROUTE_DEPTH = 4,
  localparam int SEL_W      = (SLAVES_NUM > 1) ? $clog2(SLAVES_NUM) : 1,
  localparam int PTR_W      = $clog2(ROUTE_DEPTH)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] m_awaddr,
  input  logic [ID_WIDTH-1:0]   m_awid,
  input  logic [7:0]            m_awlen,
  input  logic [2:0]            m_awsize,
  input  logic [1:0]            m_awburst,
  input  logic                  m_awlock,
  input  logic [3:0]            m_awcache,
  input  logic [2:0]            m_awprot,
  input  logic [3:0]            m_awqos,
  input  logic                  m_awvalid,
  output logic                  m_awready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic [ID_WIDTH-1:0]   s_awid,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  output logic                  s_awlock,
  output logic [3:0]            s_awcache,
  output logic [2:0]            s_awprot,
  output logic [3:0]            s_awqos,
  output logic [SLAVES_NUM-1:0] s_awvalid,
  input  logic [SLAVES_NUM-1:0] s_awready,
  output logic                  route_valid,
  output logic [SEL_W-1:0]      route_sel,
  output logic                  route_err,
  input  logic                  route_pop,
  output logic                  decerr
);

  logic [SEL_BITS-1:0]   w_idx;
  logic [SEL_W-1:0]      w_sel;
  logic                  w_mapped;
  logic                  w_hold;
  logic                  w_drain;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;
  logic                  w_pop;
  logic [SEL_W:0]        w_head;

  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [ID_WIDTH-1:0]   r_awid;
  logic [7:0]            r_awlen;
  logic [2:0]            r_awsize;
  logic [1:0]            r_awburst;
  logic                  r_awlock;
  logic [3:0]            r_awcache;
  logic [2:0]            r_awprot;
  logic [3:0]            r_awqos;
  logic [SLAVES_NUM-1:0] r_awvalid;
  logic                  r_decerr;

  logic [SEL_W:0]        r_mem [ROUTE_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W:0]        r_count;

  assign w_idx    = m_awaddr[ADDR_WIDTH-1 -: SEL_BITS];
  assign w_sel    = w_idx[SEL_W-1:0];
  assign w_mapped = (32'(w_idx) < 32'(SLAVES_NUM));

  // The one-hot valid vector doubles as the hold flag and the registered select.
  assign w_hold    = |r_awvalid;
  assign w_drain   = |(r_awvalid & s_awready);
  assign w_full    = (r_count == (PTR_W+1)'(ROUTE_DEPTH));
  assign w_empty   = (r_count == (PTR_W+1)'(0));
  assign m_awready = !ARESET && !w_full && (!w_hold || w_drain);
  assign w_accept  = m_awvalid && m_awready;
  assign w_pop     = route_pop && !w_empty;
  assign w_head    = r_mem[r_rptr];

  assign route_valid = !w_empty;
  assign route_sel   = w_empty ? {SEL_W{1'b0}} : w_head[SEL_W-1:0];
  assign route_err   = !w_empty && w_head[SEL_W];

  assign s_awaddr  = r_awaddr;
  assign s_awid    = r_awid;
  assign s_awlen   = r_awlen;
  assign s_awsize  = r_awsize;
  assign s_awburst = r_awburst;
  assign s_awlock  = r_awlock;
  assign s_awcache = r_awcache;
  assign s_awprot  = r_awprot;
  assign s_awqos   = r_awqos;
  assign s_awvalid = r_awvalid;
  assign decerr    = r_decerr;

  // Holding register: reload on a mapped accept (even while draining), clear on a lone drain.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_awaddr  <= {ADDR_WIDTH{1'b0}};
      r_awid    <= {ID_WIDTH{1'b0}};
      r_awlen   <= 8'd0;
      r_awsize  <= 3'd0;
      r_awburst <= 2'd0;
      r_awlock  <= 1'b0;
      r_awcache <= 4'd0;
      r_awprot  <= 3'd0;
      r_awqos   <= 4'd0;
      r_awvalid <= {SLAVES_NUM{1'b0}};
    end else if (w_accept && w_mapped) begin
      r_awaddr  <= m_awaddr;
      r_awid    <= m_awid;
      r_awlen   <= m_awlen;
      r_awsize  <= m_awsize;
      r_awburst <= m_awburst;
      r_awlock  <= m_awlock;
      r_awcache <= m_awcache;
      r_awprot  <= m_awprot;
      r_awqos   <= m_awqos;
      r_awvalid <= SLAVES_NUM'(1) << w_sel;
    end else if (w_drain) begin
      r_awvalid <= {SLAVES_NUM{1'b0}};
    end else begin
      r_awvalid <= r_awvalid;
    end
  end

  // Decode-error pulse for an unmapped beat, one cycle after its accept.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_decerr <= 1'b0;
    end else begin
      r_decerr <= w_accept && !w_mapped;
    end
  end

  // Routing FIFO storage; entries are only meaningful below the occupancy count.
  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      r_mem[r_wptr] <= {!w_mapped, w_sel};
    end
  end

  // Routing FIFO pointers and occupancy.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
      r_count <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_accept) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_write_addr_dec_pipelined.sv
// Scoreboard bench for write_addr_dec_pipelined with three slaves, so that the top
// quarter of the address map is unmapped and exercises the decode-error path.
module tb_write_addr_dec_pipelined;
  localparam int AW = 32;
  localparam int IW = 2;
  localparam int NS = 3;
  localparam int SB = 2;
  localparam int RD = 4;
  localparam int SW = 2;

  logic          ACLK;
  logic          ARESET;
  logic [AW-1:0] m_awaddr;
  logic [IW-1:0] m_awid;
  logic [7:0]    m_awlen;
  logic [2:0]    m_awsize;
  logic [1:0]    m_awburst;
  logic          m_awlock;
  logic [3:0]    m_awcache;
  logic [2:0]    m_awprot;
  logic [3:0]    m_awqos;
  logic          m_awvalid;
  logic          m_awready;
  logic [AW-1:0] s_awaddr;
  logic [IW-1:0] s_awid;
  logic [7:0]    s_awlen;
  logic [2:0]    s_awsize;
  logic [1:0]    s_awburst;
  logic          s_awlock;
  logic [3:0]    s_awcache;
  logic [2:0]    s_awprot;
  logic [3:0]    s_awqos;
  logic [NS-1:0] s_awvalid;
  logic [NS-1:0] s_awready;
  logic          route_valid;
  logic [SW-1:0] route_sel;
  logic          route_err;
  logic          route_pop;
  logic          decerr;

  write_addr_dec_pipelined #(
    .ADDR_WIDTH(AW), .ID_WIDTH(IW), .SLAVES_NUM(NS), .SEL_BITS(SB), .ROUTE_DEPTH(RD)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .m_awaddr(m_awaddr), .m_awid(m_awid), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache),
    .m_awprot(m_awprot), .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache),
    .s_awprot(s_awprot), .s_awqos(s_awqos), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .route_valid(route_valid), .route_sel(route_sel), .route_err(route_err),
    .route_pop(route_pop), .decerr(decerr)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
    logic [7:0]    len;
    logic [2:0]    size;
    logic [1:0]    burst;
    logic          lock;
    logic [3:0]    cache;
    logic [2:0]    prot;
    logic [3:0]    qos;
    int            idx;
  } aw_t;

  typedef struct {
    int sel;
    bit err;
  } rt_t;

  aw_t awq[$];
  rt_t rq[$];
  int  checks = 0;
  int  errors = 0;
  bit  dec_next = 1'b0;
  bit  rst_prev = 1'b0;
  bit  rand_mode = 1'b0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every DUT output against the queue model, then retire handshakes.
  always begin
    @(negedge ACLK);
    #1;
    if (ARESET) begin
      chk("awready_in_reset", 64'(m_awready), 64'd0);
      if (rst_prev) begin
        chk("rst_awvalid", 64'(s_awvalid), 64'd0);
        chk("rst_awaddr", 64'(s_awaddr), 64'd0);
        chk("rst_route_valid", 64'(route_valid), 64'd0);
        chk("rst_route_sel", 64'(route_sel), 64'd0);
        chk("rst_route_err", 64'(route_err), 64'd0);
        chk("rst_decerr", 64'(decerr), 64'd0);
      end
      awq.delete();
      rq.delete();
      dec_next = 1'b0;
      rst_prev = 1'b1;
    end else begin
      bit            hold;
      bit            drain;
      logic [NS-1:0] ev;
      rst_prev = 1'b0;
      hold  = (awq.size() != 0);
      drain = hold && s_awready[awq[0].idx];
      ev    = hold ? (NS'(1) << awq[0].idx) : '0;
      chk("m_awready", 64'(m_awready), 64'((rq.size() < RD) && (!hold || drain)));
      chk("s_awvalid", 64'(s_awvalid), 64'(ev));
      if (hold) begin
        chk("s_awaddr", 64'(s_awaddr), 64'(awq[0].addr));
        chk("s_awid", 64'(s_awid), 64'(awq[0].id));
        chk("s_awlen", 64'(s_awlen), 64'(awq[0].len));
        chk("s_awmisc", 64'({s_awsize, s_awburst, s_awlock, s_awcache, s_awprot, s_awqos}),
            64'({awq[0].size, awq[0].burst, awq[0].lock, awq[0].cache, awq[0].prot, awq[0].qos}));
      end
      chk("route_valid", 64'(route_valid), 64'(rq.size() != 0));
      chk("route_sel", 64'(route_sel), (rq.size() != 0) ? 64'(rq[0].sel) : 64'd0);
      chk("route_err", 64'(route_err), (rq.size() != 0) ? 64'(rq[0].err) : 64'd0);
      chk("decerr", 64'(decerr), 64'(dec_next));
      dec_next = 1'b0;
      if (drain) void'(awq.pop_front());
      if (route_pop && rq.size() != 0) void'(rq.pop_front());
    end
  end

  // Random slave-ready and W-mux pop behaviour while in random mode.
  always begin
    @(posedge ACLK);
    #1;
    if (rand_mode) begin
      s_awready = NS'($urandom);
      route_pop = ($urandom_range(0, 2) != 0);
    end
  end

  // Driver: present one beat, wait for the handshake, push the expected responses.
  task automatic send(input logic [AW-1:0] addr, input logic [7:0] len);
    bit  ok = 1'b0;
    aw_t t;
    int  idx;
    m_awaddr  = addr;
    m_awid    = IW'($urandom);
    m_awlen   = len;
    m_awsize  = 3'($urandom);
    m_awburst = 2'($urandom);
    m_awlock  = 1'($urandom);
    m_awcache = 4'($urandom);
    m_awprot  = 3'($urandom);
    m_awqos   = 4'($urandom);
    m_awvalid = 1'b1;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge ACLK);
      #2;
      if (m_awready) begin
        ok  = 1'b1;
        idx = int'(addr[AW-1 -: SB]);
        rq.push_back('{sel: idx % (1 << SW), err: (idx >= NS)});
        if (idx < NS) begin
          t = '{addr: addr, id: m_awid, len: len, size: m_awsize, burst: m_awburst,
                lock: m_awlock, cache: m_awcache, prot: m_awprot, qos: m_awqos, idx: idx};
          awq.push_back(t);
        end else begin
          dec_next = 1'b1;
        end
      end
      @(posedge ACLK);
      #1;
    end
    m_awvalid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: addr %0h not accepted within 60 cycles", addr);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    m_awvalid = 1'b0; m_awaddr = '0; m_awid = '0; m_awlen = '0; m_awsize = '0;
    m_awburst = '0; m_awlock = 1'b0; m_awcache = '0; m_awprot = '0; m_awqos = '0;
    s_awready = '1;
    route_pop = 1'b1;
    idle(4);
    ARESET = 1'b0;
    idle(2);

    send(32'h0000_1000, 8'd0);
    idle(3);

    s_awready = 3'b101;
    send(32'h4000_1000, 8'd1);
    fork
      send(32'h0000_2000, 8'd2);
      begin
        idle(3);
        s_awready = 3'b111;
      end
    join
    idle(3);

    send(32'h8000_0000, 8'd3);
    send(32'h4000_0040, 8'd7);
    send(32'hC000_0000, 8'd7);
    send(32'h0000_0080, 8'd0);
    idle(4);

    route_pop = 1'b0;
    send(32'h0000_0100, 8'd0);
    send(32'hC000_0100, 8'd1);
    send(32'h8000_0100, 8'd2);
    send(32'h4000_0100, 8'd3);
    fork
      send(32'h8000_0200, 8'd4);
      begin
        idle(3);
        route_pop = 1'b1;
        idle(1);
        route_pop = 1'b0;
      end
    join
    idle(2);
    route_pop = 1'b1;
    idle(6);

    s_awready = '0;
    route_pop = 1'b0;
    send(32'hC000_0300, 8'd0);
    send(32'h0000_0300, 8'd5);
    idle(1);
    ARESET = 1'b1;
    idle(1);
    ARESET = 1'b0;
    s_awready = '1;
    route_pop = 1'b1;
    idle(1);
    send(32'h4000_0400, 8'd6);
    idle(4);

    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom, 8'($urandom));
    end
    rand_mode = 1'b0;
    idle(1);
    s_awready = '1;
    route_pop = 1'b1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
